regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file's single write port. It shares the port between two write-back requesters (req0: ALU, req1: load unit) with round-robin valid/ready arbitration. It registers the winning write onto the register file's wr_en/wr_addr/wr_data. It also keeps a per-register busy scoreboard that the issue stage uses for RAW/WAW hazard checks.

## Interface
- DATA_W, default 32: write data width.
- ADDR_W, default 5: register address width (2**ADDR_W registers).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- issue_valid  in  1  issue stage claims destination issue_rd.
- issue_rd  in  ADDR_W  destination register being claimed.
- issue_ready  out  1  combinational: ~busy[issue_rd]; 1 when issue_rd==0.
- req0_valid, req1_valid  in  1  write-back request.
- req0_addr, req1_addr  in  ADDR_W  destination register.
- req0_data, req1_data  in  DATA_W  write data.
- req0_ready, req1_ready  out  1  combinational grant; a transfer occurs when valid&ready at a rising edge.
- rf_wr_en  out  1  registered write enable to the register file.
- rf_wr_addr  out  ADDR_W  registered write address.
- rf_wr_data  out  DATA_W  registered write data.
- chk_addr1, chk_addr2  in  ADDR_W  source registers to hazard-check.
- chk_busy1, chk_busy2  out  1  combinational busy[chk_addrN].
- busy  out  2**ADDR_W  scoreboard vector; bit 0 constantly 0.

## Operation
- Arbitration: at most one grant per cycle. If exactly one reqN_valid is 1, that requester is granted. If both are 1, the requester not granted last is granted. The last-grant pointer `last` updates only on an actual transfer. Reset value is last=1, so req0 wins the first tie.
- reqN_ready is 1 only for the granted requester. It is 0 for both when neither is valid. Ready depends on valid, and requesters must not make valid depend on ready.
- Accepted write, addr!=0: on the next edge, rf_wr_en<=1 and rf_wr_addr/rf_wr_data <= the granted addr/data.
- Accepted write, addr==0: the transfer is consumed (ready was 1) but rf_wr_en<=0. The pointer still updates.
- No transfer: rf_wr_en<=0. rf_wr_addr and rf_wr_data hold their values.
- Scoreboard set: issue_valid & issue_ready & issue_rd!=0 sets busy[issue_rd] at the edge.
- Scoreboard clear: rf_wr_en=1 clears busy[rf_wr_addr] at the same edge the register file performs the write. Busy therefore drops exactly when the new value becomes readable.
- Set and clear of the same register at the same edge: set wins (a new producer owns the register).
- A write to a non-busy register is legal and performed. The clear is then a no-op.
- issue_ready uses the registered busy, so an issue to a register being cleared this cycle stalls one cycle.
- busy[0] is never set.

## Timing
- Reset (rst=0, asynchronous): busy=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, last=1. Combinational outputs follow from these values.
- Reset mid-operation: in-flight registered writes and all busy bits are dropped immediately. There is no write to the register file.
- Write-back latency: transfer at edge E drives rf_wr_en in cycle E..E+1. The register file captures at edge E+1, and busy clears at edge E+1. A read in the cycle after E+1 returns the new data.
- Throughput: one write per cycle. Two requesters both held valid alternate 0,1,0,1...
- The registered outputs change only on clk edges or on reset. ready, issue_ready and chk_busy are same-cycle combinational.

## Test plan
- Reset then idle: rst=0 mid-cycle → rf_wr_en=0 and busy=0 immediately. After release with no valids, rf_wr_en stays 0.
- Single write: issue rd=5 → busy[5]=1. req1 writes addr 5, data 0xDEADBEEF → req1_ready=1, next cycle rf_wr_en=1/addr 5/data 0xDEADBEEF. busy[5]=0 after the following edge.
- Contention: both valid for 4 cycles (req0 addr 1/0x11, req1 addr 2/0x22) → grants req0,req1,req0,req1 and rf_wr_addr sequence 1,2,1,2.
- x0 write: req0 addr 0, data 0xFFFFFFFF → req0_ready=1, rf_wr_en stays 0, busy unchanged. Pointer advances, so the next tie goes to req1.
- WAW/hazard: busy[7]=1 → issue rd=7 gives issue_ready=0 and chk_addr1=7 gives chk_busy1=1. A write to 7 plus an issue of 7 at the clearing edge leaves busy[7]=1 (set wins).
- Reset mid-op: assert rst while rf_wr_en=1 for addr 9 → rf_wr_en=0 and busy[9]=0 at once. The register file write for addr 9 does not occur.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters (ALU, load unit), the arbiter,
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// plus the per-register busy scoreboard used by issue for RAW/WAW checks.
// A busy bit drops on the same edge the register file captures the write.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic                 issue_ready,
  input  logic [ADDR_W-1:0]    chk_addr1,
  input  logic [ADDR_W-1:0]    chk_addr2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic [2**ADDR_W-1:0] busy
);

  localparam int NREG = 2**ADDR_W;

  logic              last;      // 1: req1 was granted most recently
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic              issue_set;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    gnt0     = wb.req0_valid & (~wb.req1_valid | last);
    gnt1     = wb.req1_valid & (~wb.req0_valid | ~last);
    xfer     = gnt0 | gnt1;
    gnt_addr = gnt1 ? wb.req1_addr : wb.req0_addr;
    gnt_data = gnt1 ? wb.req1_data : wb.req0_data;
  end

  assign wb.req0_ready = gnt0;
  assign wb.req1_ready = gnt1;

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last      <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= xfer && (gnt_addr != '0);
      if (xfer) begin
        last <= gnt1;
        if (gnt_addr != '0) begin
          wr_addr_q <= gnt_addr;
          wr_data_q <= gnt_data;
        end
      end
    end
  end

  assign wb.rf_wr_en   = wr_en_q;
  assign wb.rf_wr_addr = wr_addr_q;
  assign wb.rf_wr_data = wr_data_q;

  // Issue readiness and hazard checks look at registered busy only.
  always_comb begin
    issue_ready = (issue_rd == '0) | ~busy_q[issue_rd];
    chk_busy1   = busy_q[chk_addr1];
    chk_busy2   = busy_q[chk_addr2];
    issue_set   = issue_valid & issue_ready & (issue_rd != '0);
  end

  // Scoreboard next state: clear on the register-file write, then set on
  // issue so a new producer keeps ownership when both hit the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_en_q) begin
      busy_nxt[wr_addr_q] = 1'b0;
    end
    if (issue_set) begin
      busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter and scoreboard. Inputs change
// just after each falling edge; outputs are sampled 1ns later (combinational)
// or at the next falling edge (registered).
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              issue_ready;
  logic [ADDR_W-1:0] chk_addr1 = '0;
  logic [ADDR_W-1:0] chk_addr2 = '0;
  logic              chk_busy1;
  logic              chk_busy2;
  logic [31:0]       busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic idle_reqs();
    wb.req0_valid = 1'b0;
    wb.req1_valid = 1'b0;
    wb.req0_addr  = '0;
    wb.req1_addr  = '0;
    wb.req0_data  = '0;
    wb.req1_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_reqs();
    #1;
    total++; if (wb.rf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wb.rf_wr_en); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (wb.rf_wr_en !== 1'b0) begin bad++; $display("FAIL idle_wr_en[%0d]: got %b want 0", i, wb.rf_wr_en); end
    end
    issue_rd = 5'd3;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL idle_issue_ready: got %b want 1", issue_ready); end
    total++; if ({wb.req0_ready, wb.req1_ready} !== 2'b00) begin bad++; $display("FAIL idle_ready: got %b want 00", {wb.req0_ready, wb.req1_ready}); end
    // mid-cycle async reset
    #2 rst = 1'b0;
    #1;
    total++; if (wb.rf_wr_addr !== 5'd0 || wb.rf_wr_data !== 32'h0) begin bad++; $display("FAIL reset_addr_data: got %h/%h want 0/0", wb.rf_wr_addr, wb.rf_wr_data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL sw_issue_ready: got %b want 1", issue_ready); end
    @(negedge clk);
    issue_valid = 1'b0;
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sw_busy_set: got %b want 1", busy[5]); end
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd5; wb.req1_data = 32'hDEADBEEF;
    #1;
    total++; if ({wb.req0_ready, wb.req1_ready} !== 2'b01) begin bad++; $display("FAIL sw_ready: got %b want 01", {wb.req0_ready, wb.req1_ready}); end
    @(negedge clk);
    idle_reqs();
    total++; if ({wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL sw_rf: got en=%b addr=%0d data=%h want en=1 addr=5 data=deadbeef", wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data);
    end
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL sw_busy_hold: got %b want 1", busy[5]); end
    @(negedge clk);
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL sw_busy_clear: got %b want 0", busy[5]); end
    total++; if (wb.rf_wr_en !== 1'b0 || wb.rf_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_after: got en=%b data=%h want en=0 data=deadbeef", wb.rf_wr_en, wb.rf_wr_data); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy [4];
    logic [4:0]  exp_addr[4];
    logic [31:0] exp_data[4];
    exp_rdy  = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_addr = '{5'd1, 5'd2, 5'd1, 5'd2};
    exp_data = '{32'h11, 32'h22, 32'h11, 32'h22};
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd1; wb.req0_data = 32'h11;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd2; wb.req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({wb.req0_ready, wb.req1_ready} !== exp_rdy[i]) begin bad++; $display("FAIL cont_ready[%0d]: got %b want %b", i, {wb.req0_ready, wb.req1_ready}, exp_rdy[i]); end
      @(negedge clk);
      total++; if ({wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data} !== {1'b1, exp_addr[i], exp_data[i]}) begin
        bad++; $display("FAIL cont_rf[%0d]: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", i, wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data, exp_addr[i], exp_data[i]);
      end
    end
    idle_reqs();
    @(negedge clk);
  endtask

  task automatic test_x0_write();
    logic [31:0] busy_snap;
    busy_snap = busy;
    issue_valid = 1'b1; issue_rd = 5'd0;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd0; wb.req0_data = 32'hFFFFFFFF;
    #1;
    total++; if (wb.req0_ready !== 1'b1) begin bad++; $display("FAIL x0_ready: got %b want 1", wb.req0_ready); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready: got %b want 1", issue_ready); end
    @(negedge clk);
    issue_valid = 1'b0;
    idle_reqs();
    total++; if (wb.rf_wr_en !== 1'b0) begin bad++; $display("FAIL x0_wr_en: got %b want 0", wb.rf_wr_en); end
    total++; if (wb.rf_wr_addr !== 5'd2 || wb.rf_wr_data !== 32'h22) begin bad++; $display("FAIL x0_hold: got %0d/%h want 2/00000022", wb.rf_wr_addr, wb.rf_wr_data); end
    total++; if (busy !== busy_snap) begin bad++; $display("FAIL x0_busy: got %h want %h", busy, busy_snap); end
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd3; wb.req0_data = 32'h33;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd4; wb.req1_data = 32'h44;
    #1;
    total++; if ({wb.req0_ready, wb.req1_ready} !== 2'b01) begin bad++; $display("FAIL x0_next_tie: got %b want 01", {wb.req0_ready, wb.req1_ready}); end
    @(negedge clk);
    idle_reqs();
    total++; if (wb.rf_wr_addr !== 5'd4 || wb.rf_wr_data !== 32'h44) begin bad++; $display("FAIL x0_tie_rf: got %0d/%h want 4/00000044", wb.rf_wr_addr, wb.rf_wr_data); end
    @(negedge clk);
  endtask

  task automatic test_hazard();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL hz_issue_first: got %b want 1", issue_ready); end
    @(negedge clk);
    chk_addr1 = 5'd7; chk_addr2 = 5'd5;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd7; wb.req0_data = 32'h77;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL hz_issue_busy: got %b want 0", issue_ready); end
    total++; if ({chk_busy1, chk_busy2} !== 2'b10) begin bad++; $display("FAIL hz_chk: got %b want 10", {chk_busy1, chk_busy2}); end
    @(negedge clk);
    idle_reqs();
    #1;
    total++; if (wb.rf_wr_en !== 1'b1 || issue_ready !== 1'b0) begin bad++; $display("FAIL hz_stall: got en=%b issue_ready=%b want 1/0", wb.rf_wr_en, issue_ready); end
    issue_valid = 1'b0;
    @(negedge clk);
    total++; if (busy[7] !== 1'b0 || chk_busy1 !== 1'b0) begin bad++; $display("FAIL hz_clear: got busy7=%b chk1=%b want 0/0", busy[7], chk_busy1); end
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd7; wb.req0_data = 32'h78;
    @(negedge clk);
    idle_reqs();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    total++; if ({wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data} !== {1'b1, 5'd7, 32'h78}) begin
      bad++; $display("FAIL hz_rf2: got en=%b addr=%0d data=%h want 1/7/00000078", wb.rf_wr_en, wb.rf_wr_addr, wb.rf_wr_data);
    end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL hz_issue_free: got %b want 1", issue_ready); end
    @(negedge clk);
    issue_valid = 1'b0;
    total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL hz_set_wins: got %b want 1", busy[7]); end
  endtask

  task automatic test_reset_midop();
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0;
    total++; if (busy[9] !== 1'b1) begin bad++; $display("FAIL rm_busy_set: got %b want 1", busy[9]); end
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd9; wb.req0_data = 32'h99;
    @(negedge clk);
    idle_reqs();
    total++; if (wb.rf_wr_en !== 1'b1 || wb.rf_wr_addr !== 5'd9) begin bad++; $display("FAIL rm_inflight: got en=%b addr=%0d want 1/9", wb.rf_wr_en, wb.rf_wr_addr); end
    #2 rst = 1'b0;
    #1;
    total++; if (wb.rf_wr_en !== 1'b0 || busy !== 32'h0) begin bad++; $display("FAIL rm_drop: got en=%b busy=%h want 0/0", wb.rf_wr_en, busy); end
    total++; if (wb.rf_wr_addr !== 5'd0 || wb.rf_wr_data !== 32'h0) begin bad++; $display("FAIL rm_regs: got %0d/%h want 0/0", wb.rf_wr_addr, wb.rf_wr_data); end
    @(negedge clk);
    rst = 1'b1;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd10; wb.req0_data = 32'hA0;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd11; wb.req1_data = 32'hB0;
    #1;
    total++; if ({wb.req0_ready, wb.req1_ready} !== 2'b10) begin bad++; $display("FAIL rm_last_reset: got %b want 10", {wb.req0_ready, wb.req1_ready}); end
    @(negedge clk);
    idle_reqs();
  endtask

  initial begin
    idle_reqs();
    test_reset();
    test_single_write();
    test_contention();
    test_x0_write();
    test_hazard();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
